// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response, ALU-side and status signals for alu_share_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_share_arbiter_if #(
  parameter int N = 32
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a requester holds valid and payload stable until it sees ready, the arbiter holds
  // rspX_valid and response data stable until it sees the matching rspX_ready.
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [2:0]   req0_op;
  logic [4:0]   req0_shamt;
  logic [1:0]   req0_shtype;
  logic         req0_setf;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [2:0]   req1_op;
  logic [4:0]   req1_shamt;
  logic [1:0]   req1_shtype;
  logic         req1_setf;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_control;
  logic [4:0]   alu_shamt;
  logic [1:0]   alu_shtype;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;

  logic [3:0]   status_nzcv;
  logic         busy;
  logic [1:0]   state_dbg;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_shamt, req0_shtype, req0_setf,
    input  req1_valid, req1_a, req1_b, req1_op, req1_shamt, req1_shtype, req1_setf,
    input  rsp0_ready, rsp1_ready, alu_result, alu_flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err,
    output alu_a, alu_b, alu_control, alu_shamt, alu_shtype, status_nzcv, busy, state_dbg
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_shamt, req0_shtype, req0_setf,
    output req1_valid, req1_a, req1_b, req1_op, req1_shamt, req1_shtype, req1_setf,
    output rsp0_ready, rsp1_ready, alu_result, alu_flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err,
    input  alu_a, alu_b, alu_control, alu_shamt, alu_shtype, status_nzcv, busy, state_dbg
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU between the execute stage (0)
// and the debug port (1), with a registered NZCV status register updated on request.
module alu_share_arbiter #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic         r_ptr;
  logic         r_gnt;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [2:0]   r_op;
  logic [4:0]   r_shamt;
  logic [1:0]   r_shtype;
  logic         r_setf;
  logic [N-1:0] r_result;
  logic [3:0]   r_flags;
  logic         r_err;
  logic [3:0]   r_nzcv;

  logic         w_gnt1;
  logic         w_accept;
  logic         w_rsp_hs;
  logic         w_ready0;
  logic         w_ready1;
  logic         w_rsp0_valid;
  logic         w_rsp1_valid;
  logic         w_op_ok;

  assign w_op_ok = (r_op <= 3'b100);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant is only meaningful in IDLE; the pointer breaks ties when both requesters are valid.
  always_comb begin
    w_next       = r_state;
    w_gnt1       = 1'b0;
    w_accept     = 1'b0;
    w_rsp_hs     = 1'b0;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    w_rsp0_valid = 1'b0;
    w_rsp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt1   = bus.req1_valid && (!bus.req0_valid || r_ptr);
        w_accept = bus.req0_valid || bus.req1_valid;
        w_ready0 = bus.req0_valid && !w_gnt1;
        w_ready1 = w_gnt1;
        if (w_accept) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        w_rsp0_valid = !r_gnt;
        w_rsp1_valid = r_gnt;
        w_rsp_hs     = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;
        if (w_rsp_hs) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= 1'b0;
      r_gnt    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 3'b000;
      r_shamt  <= 5'd0;
      r_shtype <= 2'd0;
      r_setf   <= 1'b0;
      r_result <= '0;
      r_flags  <= 4'b0000;
      r_err    <= 1'b0;
      r_nzcv   <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_gnt    <= w_gnt1;
        r_a      <= w_gnt1 ? bus.req1_a      : bus.req0_a;
        r_b      <= w_gnt1 ? bus.req1_b      : bus.req0_b;
        r_op     <= w_gnt1 ? bus.req1_op     : bus.req0_op;
        r_shamt  <= w_gnt1 ? bus.req1_shamt  : bus.req0_shamt;
        r_shtype <= w_gnt1 ? bus.req1_shtype : bus.req0_shtype;
        r_setf   <= w_gnt1 ? bus.req1_setf   : bus.req0_setf;
      end
      // Illegal ops report a zero result with only Z set and never touch NZCV.
      if (r_state == S_EXEC) begin
        r_err    <= !w_op_ok;
        r_result <= w_op_ok ? bus.alu_result : '0;
        r_flags  <= w_op_ok ? bus.alu_flags : 4'b0100;
        if (w_op_ok && r_setf) r_nzcv <= bus.alu_flags;
      end
      if (w_rsp_hs) r_ptr <= ~r_gnt;
    end
  end

  assign bus.req0_ready  = w_ready0;
  assign bus.req1_ready  = w_ready1;
  assign bus.rsp0_valid  = w_rsp0_valid;
  assign bus.rsp1_valid  = w_rsp1_valid;
  assign bus.rsp_result  = r_result;
  assign bus.rsp_flags   = r_flags;
  assign bus.rsp_err     = r_err;
  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_control = r_op;
  assign bus.alu_shamt   = r_shamt;
  assign bus.alu_shtype  = r_shtype;
  assign bus.status_nzcv = r_nzcv;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized two-requester run scored against a transaction-level model.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_checks;

  alu_share_arbiter_if #(.N(32)) bus ();

  alu_share_arbiter #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  // ---------------- reference ALU (also models the external ALU) ----------------
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic [4:0] sh,
                                          input logic [1:0] st);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin
        case (st)
          2'd0:    r = a << sh;
          2'd1:    r = a >> sh;
          2'd2:    r = 32'($signed(a) >>> sh);
          default: r = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
        endcase
      end
      default: return {4'b1111, 32'hDEADBEEF};
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb begin
    {bus.alu_flags, bus.alu_result} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_control,
                                              bus.alu_shamt, bus.alu_shtype);
  end

  // {err, flags, result} the requester should see for a given operation
  function automatic logic [36:0] exp_of(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic [4:0] sh,
                                         input logic [1:0] st);
    if (op > 3'd4) return {1'b1, 4'b0100, 32'd0};
    return {1'b0, alu_ref(a, b, op, sh, st)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [4:0] sh, input logic [1:0] st,
                         input logic sf);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      bus.req0_shamt = sh; bus.req0_shtype = st; bus.req0_setf = sf;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      bus.req1_shamt = sh; bus.req1_shtype = st; bus.req1_setf = sf;
    end
  endtask

  task automatic clear_inputs();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 2'd0, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 2'd0, 1'b0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_req(input int id);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(id, 1'b1, a, b, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  sh;
    logic [1:0]  st;
    logic        sf;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        err;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input logic [4:0] sh, input logic [1:0] st, input logic sf,
                              input logic [31:0] res, input logic [3:0] fl, input logic err,
                              input logic [3:0] nzcv);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.sh = sh; v.st = st; v.sf = sf;
    v.res = res; v.fl = fl; v.err = err; v.nzcv = nzcv;
    return v;
  endfunction

  // One requester-0 op: accept in cycle 0, response from cycle 2, taken immediately.
  task automatic run_op0(input vec_t v);
    @(posedge clk); #1;
    set_req(0, 1'b1, v.a, v.b, v.op, v.sh, v.st, v.sf);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    chk("vec_ready0_c0", bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("vec_busy_c1", bus.busy, 1);
    chk("vec_rsp0_valid_c1", bus.rsp0_valid, 0);
    chk("vec_alu_control", bus.alu_control, v.op);
    @(negedge clk);
    chk("vec_rsp0_valid_c2", bus.rsp0_valid, 1);
    chk("vec_result", bus.rsp_result, v.res);
    chk("vec_flags", bus.rsp_flags, v.fl);
    chk("vec_err", bus.rsp_err, v.err);
    @(negedge clk);
    chk("vec_rsp0_done", bus.rsp0_valid, 0);
    chk("vec_busy_idle", bus.busy, 0);
    chk("vec_nzcv", bus.status_nzcv, v.nzcv);
  endtask

  // ---------------- scoreboard state for the random run ----------------
  logic [37:0] exp_q[$];   // {id, err, flags, result}
  logic [3:0]  m_nzcv;
  logic        prefer;
  int          acc_cyc;

  initial begin
    logic [37:0] e;
    logic [36:0] x;
    logic        w;
    logic        exp_v;
    logic        acc0;
    logic        acc1;

    n_err = 0;
    n_checks = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_flags", bus.rsp_flags, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_nzcv", bus.status_nzcv, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    vecs[0]  = mk(32'd5, 32'd3, 3'd0, 5'd0, 2'd0, 1'b1, 32'd8, 4'b0000, 1'b0, 4'b0000);
    vecs[1]  = mk(32'd3, 32'd3, 3'd1, 5'd0, 2'd0, 1'b1, 32'd0, 4'b0110, 1'b0, 4'b0110);
    vecs[2]  = mk(32'h7FFFFFFF, 32'd1, 3'd0, 5'd0, 2'd0, 1'b0, 32'h80000000, 4'b1001, 1'b0, 4'b0110);
    vecs[3]  = mk(32'd9, 32'd4, 3'd6, 5'd0, 2'd0, 1'b1, 32'd0, 4'b0100, 1'b1, 4'b0110);
    vecs[4]  = mk(32'hF0, 32'h0F, 3'd3, 5'd0, 2'd0, 1'b1, 32'hFF, 4'b0000, 1'b0, 4'b0000);
    vecs[5]  = mk(32'hFF00, 32'h0FF0, 3'd2, 5'd0, 2'd0, 1'b1, 32'h0F00, 4'b0000, 1'b0, 4'b0000);
    vecs[6]  = mk(32'd1, 32'd0, 3'd4, 5'd31, 2'd0, 1'b1, 32'h80000000, 4'b1000, 1'b0, 4'b1000);
    vecs[7]  = mk(32'hFFFFFFFF, 32'd1, 3'd0, 5'd0, 2'd0, 1'b0, 32'd0, 4'b0110, 1'b0, 4'b1000);
    vecs[8]  = mk(32'h80000000, 32'd1, 3'd1, 5'd0, 2'd0, 1'b1, 32'h7FFFFFFF, 4'b0011, 1'b0, 4'b0011);
    vecs[9]  = mk(32'h80000000, 32'd0, 3'd4, 5'd4, 2'd2, 1'b1, 32'hF8000000, 4'b1000, 1'b0, 4'b1000);
    vecs[10] = mk(32'd1, 32'd1, 3'd7, 5'd0, 2'd0, 1'b0, 32'd0, 4'b0100, 1'b1, 4'b1000);
    vecs[11] = mk(32'd1, 32'd0, 3'd4, 5'd1, 2'd3, 1'b0, 32'h80000000, 4'b1000, 1'b0, 4'b1000);
    for (int i = 0; i < 12; i++) run_op0(vecs[i]);

    // Conflict after reset: requester 0 first, then the pointer favours requester 1.
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd3, 32'd3, 3'd1, 5'd0, 2'd0, 1'b1);
    set_req(1, 1'b1, 32'hF0, 32'h0F, 3'd3, 5'd0, 2'd0, 1'b0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("cf_ready0", bus.req0_ready, 1);
    chk("cf_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("cf_ready1_exec", bus.req1_ready, 0);
    @(negedge clk);
    chk("cf_rsp0_valid", bus.rsp0_valid, 1);
    chk("cf_rsp1_idle", bus.rsp1_valid, 0);
    chk("cf_result0", bus.rsp_result, 32'd0);
    chk("cf_flags0", bus.rsp_flags, 4'b0110);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h10, 32'h20, 3'd0, 5'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("cf2_ready1", bus.req1_ready, 1);
    chk("cf2_ready0", bus.req0_ready, 0);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("cf_rsp1_valid", bus.rsp1_valid, 1);
    chk("cf_rsp0_quiet", bus.rsp0_valid, 0);
    chk("cf_result1", bus.rsp_result, 32'hFF);
    chk("cf_flags1", bus.rsp_flags, 4'b0000);
    @(negedge clk);
    chk("cf3_ready0", bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("cf3_result", bus.rsp_result, 32'h30);
    @(negedge clk);
    chk("cf_nzcv", bus.status_nzcv, 4'b0110);

    // Backpressure on requester 1 while requester 0 waits; rsp0_ready must be ignored.
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'd1, 32'd2, 3'd0, 5'd0, 2'd0, 1'b1);
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready1", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    set_req(0, 1'b1, 32'd7, 32'd8, 3'd0, 5'd0, 2'd0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp1_valid", bus.rsp1_valid, 1);
      chk("bp_rsp0_valid", bus.rsp0_valid, 0);
      chk("bp_result", bus.rsp_result, 32'd3);
      chk("bp_ready0", bus.req0_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_rsp1_done", bus.rsp1_valid, 0);
    chk("bp_ready0_after", bus.req0_ready, 1);
    chk("bp_nzcv", bus.status_nzcv, 4'b0000);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_result0", bus.rsp_result, 32'd15);
    @(negedge clk);

    // Reset in RESP drops the op and its NZCV update; priority returns to requester 0.
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'hFFFFFFFF, 32'd1, 3'd0, 5'd0, 2'd0, 1'b1);
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    chk("rr_ready1", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr_rsp1_valid", bus.rsp1_valid, 1);
    chk("rr_nzcv_loaded", bus.status_nzcv, 4'b0110);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_rsp1_cleared", bus.rsp1_valid, 0);
    chk("rr_result_cleared", bus.rsp_result, 0);
    chk("rr_flags_cleared", bus.rsp_flags, 0);
    chk("rr_nzcv_cleared", bus.status_nzcv, 0);
    chk("rr_busy_cleared", bus.busy, 0);
    chk("rr_alu_a_cleared", bus.alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd1, 32'd1, 3'd0, 5'd0, 2'd0, 1'b0);
    set_req(1, 1'b1, 32'd2, 32'd2, 3'd0, 5'd0, 2'd0, 1'b0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("rr_prio_ready0", bus.req0_ready, 1);
    chk("rr_prio_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    clear_inputs();
    bus.rsp0_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized traffic from both requesters against the transaction model.
    do_reset();
    m_nzcv = 4'b0000;
    prefer = 1'b0;
    acc_cyc = 0;
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && cyc < 560 && $urandom_range(0, 2) == 0) rand_req(0);
      if (!bus.req1_valid && cyc < 560 && $urandom_range(0, 2) == 0) rand_req(1);
      bus.rsp0_ready = (cyc >= 560) || ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = (cyc >= 560) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        exp_v = (cyc >= acc_cyc + 2);
        chk("rnd_ready0_held", bus.req0_ready, 0);
        chk("rnd_ready1_held", bus.req1_ready, 0);
        chk("rnd_busy", bus.busy, 1);
        chk("rnd_rsp0_valid", bus.rsp0_valid, exp_v && !e[37]);
        chk("rnd_rsp1_valid", bus.rsp1_valid, exp_v && e[37]);
        if (exp_v && (e[37] ? bus.rsp1_ready : bus.rsp0_ready)) begin
          e = exp_q.pop_front();
          chk("rnd_result", bus.rsp_result, e[31:0]);
          chk("rnd_flags", bus.rsp_flags, e[35:32]);
          chk("rnd_err", bus.rsp_err, e[36]);
          chk("rnd_nzcv", bus.status_nzcv, m_nzcv);
          prefer = !e[37];
        end
      end else begin
        chk("rnd_idle_rsp0", bus.rsp0_valid, 0);
        chk("rnd_idle_rsp1", bus.rsp1_valid, 0);
        chk("rnd_idle_busy", bus.busy, 0);
        if (bus.req0_valid || bus.req1_valid) begin
          w = (bus.req0_valid && bus.req1_valid) ? prefer : bus.req1_valid;
          chk("rnd_grant0", bus.req0_ready, !w);
          chk("rnd_grant1", bus.req1_ready, w);
          if (w) begin
            x = exp_of(bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_shamt, bus.req1_shtype);
            if (bus.req1_setf && !x[36]) m_nzcv = x[35:32];
            acc1 = 1'b1;
          end else begin
            x = exp_of(bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_shamt, bus.req0_shtype);
            if (bus.req0_setf && !x[36]) m_nzcv = x[35:32];
            acc0 = 1'b1;
          end
          exp_q.push_back({w, x});
          acc_cyc = cyc;
        end else begin
          chk("rnd_noreq_ready0", bus.req0_ready, 0);
          chk("rnd_noreq_ready1", bus.req1_ready, 0);
        end
      end
    end
    chk("rnd_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
